card_datapath: RTL and testbench

//   Responder to the baccarat hand-sequencing state machine. Consumes its six load strobes
//   (load_pcard1..3, load_dcard1..3), deals a card on each strobe from an internal dealer

---
 rtl/card_datapath.sv | 135 +++++++++++++
 tb/tb_card_datapath.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_datapath.sv
// Card datapath for the baccarat hand sequencer: deals cards on load strobes and derives scores.
// Define LFSR_DEAL_EN to replace the wrap counter dealer source with an 8-bit LFSR.
module card_datapath #(
  parameter int unsigned RANK_MIN = 1,
  parameter int unsigned RANK_MAX = 13
`ifdef LFSR_DEAL_EN
  ,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
`endif
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1_r,
  output logic [3:0] pcard2_r,
  output logic [3:0] pcard3_r,
  output logic [3:0] dcard1_r,
  output logic [3:0] dcard2_r,
  output logic [3:0] dcard3_r,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3,
  output logic       load_err,
  output logic [7:0] hand_count
);

  // Slot order: 0..2 player cards 1..3, 3..5 dealer cards 1..3
  logic [5:0] w_load;
  logic [3:0] w_card;
  logic       w_multi;
  logic [3:0] r_card [6];
  logic       r_load_err;
  logic [7:0] r_hand;

  assign w_load  = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
  // Clearing the lowest set bit leaves something only when two or more strobes are high
  assign w_multi = |(w_load & (w_load - 6'd1));

`ifdef LFSR_DEAL_EN
  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign w_card = 4'((32'(r_lfsr) % (RANK_MAX - RANK_MIN + 1)) + RANK_MIN);
`else
  logic [3:0] r_cnt;

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'(RANK_MIN);
    end else if (r_cnt == 4'(RANK_MAX)) begin
      r_cnt <= 4'(RANK_MIN);
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign w_card = r_cnt;
`endif

  // A player-card-1 strobe starts a new hand; any slot strobed on the same edge still deals
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        r_card[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_load[i]) begin
          r_card[i] <= w_card;
        end else if (w_load[0]) begin
          r_card[i] <= 4'd0;
        end
      end
    end
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_load_err <= 1'b0;
      r_hand     <= 8'd0;
    end else begin
      if (w_multi) begin
        r_load_err <= 1'b1;
      end
      if (w_load[0]) begin
        r_hand <= r_hand + 8'd1;
      end
    end
  end

  function automatic logic [3:0] card_val(input logic [3:0] rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

  logic [3:0] w_val [6];
  logic [4:0] w_psum;
  logic [4:0] w_dsum;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_val[i] = card_val(r_card[i]);
    end
  end

  assign w_psum = 5'(w_val[0]) + 5'(w_val[1]) + 5'(w_val[2]);
  assign w_dsum = 5'(w_val[3]) + 5'(w_val[4]) + 5'(w_val[5]);

  assign pscore     = 4'(w_psum % 5'd10);
  assign dscore     = 4'(w_dsum % 5'd10);
  assign pcard3     = w_val[2];
  assign pcard1_r   = r_card[0];
  assign pcard2_r   = r_card[1];
  assign pcard3_r   = r_card[2];
  assign dcard1_r   = r_card[3];
  assign dcard2_r   = r_card[4];
  assign dcard3_r   = r_card[5];
  assign load_err   = r_load_err;
  assign hand_count = r_hand;

endmodule

// File: tb/tb_card_datapath.sv
// Self-checking bench for card_datapath: directed scenarios plus random strobes against a model.
`timescale 1ns/1ps
module tb_card_datapath;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic [3:0] pcard1_r, pcard2_r, pcard3_r, dcard1_r, dcard2_r, dcard3_r;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_err;
  logic [7:0] hand_count;

  int errors = 0;
  int checks = 0;

  // Model state: dealer position, cards indexed p1,p2,p3,d1,d2,d3
  int m_cnt;
  int m_card [6];
  int m_err;
  int m_hand;

  card_datapath dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
    .pcard1_r   (pcard1_r),
    .pcard2_r   (pcard2_r),
    .pcard3_r   (pcard3_r),
    .dcard1_r   (dcard1_r),
    .dcard2_r   (dcard2_r),
    .dcard3_r   (dcard3_r),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard3     (pcard3),
    .load_err   (load_err),
    .hand_count (hand_count)
  );

  always #5 slow_clock = ~slow_clock;

  logic [44:0] w_obs;
  assign w_obs = {pcard1_r, pcard2_r, pcard3_r, dcard1_r, dcard2_r, dcard3_r,
                  pscore, dscore, pcard3, load_err, hand_count};

  function automatic int val(input int rank);
    return (rank >= 1 && rank <= 9) ? rank : 0;
  endfunction

  function automatic logic [44:0] exp_vec();
    int ps;
    int ds;
    ps = (val(m_card[0]) + val(m_card[1]) + val(m_card[2])) % 10;
    ds = (val(m_card[3]) + val(m_card[4]) + val(m_card[5])) % 10;
    return {4'(m_card[0]), 4'(m_card[1]), 4'(m_card[2]), 4'(m_card[3]), 4'(m_card[4]),
            4'(m_card[5]), 4'(ps), 4'(ds), 4'(val(m_card[2])), 1'(m_err), 8'(m_hand)};
  endfunction

  function automatic void model_reset();
    m_cnt = 1;
    for (int i = 0; i < 6; i++) m_card[i] = 0;
    m_err  = 0;
    m_hand = 0;
  endfunction

  function automatic void model_edge(input logic [5:0] s);
    int dealt;
    int n;
    dealt = m_cnt;
    n = 0;
    if (s[0]) begin
      for (int i = 1; i < 6; i++) m_card[i] = 0;
      m_hand = (m_hand + 1) % 256;
    end
    for (int i = 0; i < 6; i++) begin
      if (s[i]) begin
        m_card[i] = dealt;
        n++;
      end
    end
    if (n > 1) m_err = 1;
    m_cnt = (m_cnt == 13) ? 1 : m_cnt + 1;
  endfunction

  // Bit order: 0 p1, 1 p2, 2 p3, 3 d1, 4 d2, 5 d3. Called at a falling edge.
  task automatic tick(input logic [5:0] s);
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = s;
    @(posedge slow_clock);
    model_edge(s);
    @(negedge slow_clock);
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'd0;
  endtask

  task automatic idle_until(input int rank);
    while (m_cnt != rank) tick(6'd0);
  endtask

  task automatic power_on();
    reset = 1'b0;
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'd0;
    #1 reset = 1'b1;
    model_reset();
    @(negedge slow_clock);
    @(negedge slow_clock);
    reset = 1'b0;
    checks++;
    if (w_obs !== exp_vec()) begin
      errors++;
      $display("FAIL power_on: got %h expected %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_basic();
    tick(6'b000001);
    tick(6'b001000);
    tick(6'b000010);
    tick(6'b010000);
    checks++;
    if ({pcard1_r, dcard1_r, pcard2_r, dcard2_r} !== 16'h1234) begin
      errors++;
      $display("FAIL basic_ranks: got %h expected 1234",
               {pcard1_r, dcard1_r, pcard2_r, dcard2_r});
    end
    checks++;
    if (pscore !== 4'd4 || dscore !== 4'd6) begin
      errors++;
      $display("FAIL basic_scores: got %0d/%0d expected 4/6", pscore, dscore);
    end
    checks++;
    if (hand_count !== 8'd1) begin
      errors++;
      $display("FAIL basic_hand: got %0d expected 1", hand_count);
    end
  endtask

  task automatic test_pcard3();
    idle_until(12);
    tick(6'b000100);
    checks++;
    if (pcard3_r !== 4'd12 || pcard3 !== 4'd0 || pscore !== 4'd4) begin
      errors++;
      $display("FAIL pcard3_face: got r=%0d v=%0d ps=%0d expected 12/0/4",
               pcard3_r, pcard3, pscore);
    end
  endtask

  task automatic test_wrap();
    idle_until(9);
    tick(6'b000001);
    idle_until(8);
    tick(6'b000010);
    checks++;
    if (pscore !== 4'd7) begin
      errors++;
      $display("FAIL score_mod: got %0d expected 7", pscore);
    end
    idle_until(13);
    tick(6'b100000);
    tick(6'b001000);
    checks++;
    if (dcard3_r !== 4'd13 || dcard1_r !== 4'd1 || dscore !== 4'd1) begin
      errors++;
      $display("FAIL wrap: got d3=%0d d1=%0d ds=%0d expected 13/1/1",
               dcard3_r, dcard1_r, dscore);
    end
  endtask

  task automatic test_new_hand();
    int dealt;
    int hand0;
    for (int i = 0; i < 6; i++) tick(6'(1 << i));
    checks++;
    if (w_obs !== exp_vec()) begin
      errors++;
      $display("FAIL full_hand: got %h expected %h", w_obs, exp_vec());
    end
    dealt = m_cnt;
    hand0 = m_hand;
    tick(6'b000001);
    checks++;
    if ({pcard2_r, pcard3_r, dcard1_r, dcard2_r, dcard3_r} !== 20'h0 ||
        pcard1_r !== 4'(dealt)) begin
      errors++;
      $display("FAIL new_hand_cards: got p1=%0d rest=%h expected p1=%0d rest=0", pcard1_r,
               {pcard2_r, pcard3_r, dcard1_r, dcard2_r, dcard3_r}, dealt);
    end
    checks++;
    if (hand_count !== 8'(hand0 + 1) || pscore !== 4'(val(dealt)) || dscore !== 4'd0) begin
      errors++;
      $display("FAIL new_hand_state: got hc=%0d ps=%0d ds=%0d expected %0d/%0d/0",
               hand_count, pscore, dscore, hand0 + 1, val(dealt));
    end
  endtask

  task automatic test_multi();
    int dealt;
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", load_err);
    end
    dealt = m_cnt;
    tick(6'b010010);
    checks++;
    if (pcard2_r !== 4'(dealt) || dcard2_r !== 4'(dealt) || load_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_load: got p2=%0d d2=%0d err=%b expected %0d/%0d/1",
               pcard2_r, dcard2_r, load_err, dealt, dealt);
    end
    for (int i = 0; i < 3; i++) tick(6'd0);
    dealt = m_cnt;
    tick(6'b001001);
    checks++;
    if (pcard1_r !== 4'(dealt) || dcard1_r !== 4'(dealt) || pcard2_r !== 4'd0 ||
        dcard2_r !== 4'd0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL hand_with_d1: got p1=%0d d1=%0d p2=%0d d2=%0d err=%b expected %0d/%0d/0/0/1",
               pcard1_r, dcard1_r, pcard2_r, dcard2_r, load_err, dealt, dealt);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) tick(6'(1 << i));
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (w_obs !== 45'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", w_obs);
    end
    @(negedge slow_clock);
    reset = 1'b0;
    tick(6'b000010);
    checks++;
    if (pcard2_r !== 4'd1 || w_obs !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset_deal: got %h expected %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [5:0] s;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 6; b++) s[b] = ($urandom_range(3) == 0);
      tick(s);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d] s=%b: got %h expected %h", n, s, w_obs, exp_vec());
      end
      if ($urandom_range(39) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (w_obs !== exp_vec()) begin
          errors++;
          $display("FAIL random_reset[%0d]: got %h expected %h", n, w_obs, exp_vec());
        end
        @(negedge slow_clock);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    power_on();
    test_basic();
    test_pcard3();
    test_wrap();
    test_new_hand();
    test_reset();
    test_multi();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
